// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding,
// run-mode codes and the default counter width.
package counter_pkg;

    // Sequencer states. UP/DOWN are the two run states; the encoding is
    // also presented on the state_dbg port of the top level.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_t;

    // Run-mode codes carried on cfg_mode.
    localparam logic [1:0] MODE_ONESHOT_UP = 2'b00;
    localparam logic [1:0] MODE_ONESHOT_DN = 2'b01;
    localparam logic [1:0] MODE_BOUNCE     = 2'b10;
    localparam logic [1:0] MODE_WRAP       = 2'b11;

    // Default counter / limit width.
    localparam int DEFAULT_WIDTH = 4;

    // True for the states in which the counter is stepping.
    function automatic logic is_run_state(state_t s);
        return (s == UP) || (s == DOWN);
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step tick generator: asserts tick on every DIV-th enabled cycle.
// A synchronous clear restarts the division so the first tick after a
// clear comes DIV enabled cycles later. DIV = 1 gives a tick on every
// enabled cycle.
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    // Tick on the last cycle of each DIV-cycle window.
    assign tick = en && (pcnt == LAST);

    // Divider counter: clear wins, otherwise advance while enabled and
    // wrap to 0 on the ticking cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: accepts a limit/mode configuration, then runs a
// WIDTH-bit counter in one-shot up, one-shot down, bounce or wrap mode
// until completion or stop. All outputs are registered.
//
// Build option: define COUNTER_SEQUENCER_PRESCALE_EN to step the counter
// once every DIV cycles through step_prescaler; without it the counter
// steps on every run cycle and DIV is unused.
//
// Configuration handshake: a configuration transfers on a cycle where
// cfg_valid and cfg_ready are both 1. cfg_ready is a registered output,
// high in IDLE and ARMED and low while a run is in progress; it never
// depends combinationally on cfg_valid, start or stop. A transfer has
// priority over a same-cycle start or stop.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [1:0]       cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             turn,
    output logic [1:0]       state_dbg
);

    state_t           state;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             step;

    logic             cfg_fire;
    logic             start_fire;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] dn_next;
    logic             at_limit;
    logic             at_zero;

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign start_fire = (state == ARMED) && start && !cfg_valid && !stop;
    assign up_next    = count + 1'b1;
    assign dn_next    = count - 1'b1;
    assign at_limit   = (count == limit);
    assign at_zero    = (count == '0);
    assign state_dbg  = state;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
    logic run_state;
    logic presc_clr;

    // Prescaler runs only in UP/DOWN; it restarts on start acceptance
    // and on stop. Reversals land on a tick, which already wraps it.
    assign run_state = is_run_state(state);
    assign presc_clr = start_fire || stop;

    step_prescaler #(
        .DIV (DIV)
    ) u_step_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (run_state),
        .tick  (step)
    );
`else
    logic unused_div;

    // Step on every run cycle; DIV has no effect in this build.
    assign step       = 1'b1;
    assign unused_div = (DIV > 0);
`endif

    // Sequencer FSM with registered outputs: configuration, run control
    // and per-mode stepping with completion/turn pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            limit     <= '0;
            mode      <= MODE_ONESHOT_UP;
            dir       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            turn      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            turn <= 1'b0;

            case (state)
                IDLE, ARMED: begin
                    if (cfg_fire) begin
                        // Latch a new configuration and preset the counter.
                        limit <= cfg_limit;
                        mode  <= cfg_mode;
                        state <= ARMED;
                        if (cfg_mode == MODE_ONESHOT_DN) begin
                            count <= cfg_limit;
                            dir   <= 1'b0;
                        end else begin
                            count <= '0;
                            dir   <= 1'b1;
                        end
                    end else if (stop) begin
                        state <= IDLE;
                    end else if (start_fire) begin
                        // Start only counts in ARMED; it launches the run.
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        state     <= (mode == MODE_ONESHOT_DN) ? DOWN : UP;
                    end
                end

                UP, DOWN: begin
                    if (stop) begin
                        // Abort: count and dir hold, no done/turn pulse.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (step) begin
                        case (mode)
                            MODE_ONESHOT_UP: begin
                                // Already at the limit means a zero-length run.
                                if (!at_limit) begin
                                    count <= up_next;
                                end
                                if (at_limit || (up_next == limit)) begin
                                    done      <= 1'b1;
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    cfg_ready <= 1'b1;
                                end
                            end

                            MODE_ONESHOT_DN: begin
                                if (!at_zero) begin
                                    count <= dn_next;
                                end
                                if (at_zero || (dn_next == '0)) begin
                                    done      <= 1'b1;
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    cfg_ready <= 1'b1;
                                end
                            end

                            MODE_BOUNCE: begin
                                // A zero limit parks the counter at 0.
                                if (limit != '0) begin
                                    if (state == UP) begin
                                        count <= up_next;
                                        if (up_next == limit) begin
                                            turn  <= 1'b1;
                                            dir   <= 1'b0;
                                            state <= DOWN;
                                        end
                                    end else begin
                                        count <= dn_next;
                                        if (dn_next == '0) begin
                                            turn  <= 1'b1;
                                            dir   <= 1'b1;
                                            state <= UP;
                                        end
                                    end
                                end
                            end

                            default: begin
                                // Wrap: the step after reaching the limit reloads 0.
                                if (at_limit) begin
                                    count <= '0;
                                    turn  <= 1'b1;
                                end else begin
                                    count <= up_next;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer. A reference model computes the counter
// value of a run directly from the number of steps taken since start
// (closed-form per mode) and queues the expected outputs every clock; a
// monitor compares the DUT outputs against that queue mid-cycle.
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int W   = 4;
  localparam int DIV = 4;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  localparam int STEP_EVERY = DIV;
`else
  localparam int STEP_EVERY = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_limit;
  logic [1:0]   cfg_mode;
  logic         start;
  logic         stop;
  logic [W-1:0] count;
  logic         dir;
  logic         busy;
  logic         done;
  logic         turn;
  logic [1:0]   state_dbg;

  // Expected {cfg_ready, busy, dir, done, turn, count} per clock.
  logic [W+4:0] exp_q[$];
  int           checks;
  int           errors;

  counter_sequencer #(
    .WIDTH (W),
    .DIV   (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_limit (cfg_limit),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .turn      (turn),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 configured (armed), 2 running
  int m_phase;
  int m_limit;
  int m_mode;
  int m_count;
  int m_dir;
  int m_k;     // steps taken in the current run
  int m_cyc;   // cycles spent in the current run

  task automatic model_edge();
    logic         e_done;
    logic         e_turn;
    logic [W-1:0] e_count;
    int           p;
    int           span;
    e_done = 1'b0;
    e_turn = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_limit = 0; m_mode = 0; m_count = 0; m_dir = 1;
      m_k = 0; m_cyc = 0;
    end else if (m_phase != 2) begin
      if (cfg_valid) begin
        m_limit = int'(cfg_limit);
        m_mode  = int'(cfg_mode);
        m_count = (m_mode == 1) ? m_limit : 0;
        m_dir   = (m_mode == 1) ? 0 : 1;
        m_phase = 1;
      end else if (stop) begin
        m_phase = 0;
      end else if (m_phase == 1 && start) begin
        m_phase = 2;
        m_k     = 0;
        m_cyc   = 0;
      end
    end else if (stop) begin
      m_phase = 0;
    end else begin
      m_cyc++;
      if (m_cyc % STEP_EVERY == 0) begin
        m_k++;
        case (m_mode)
          0, 1: begin
            // One-shot: travels min(k, limit) and ends after
            // max(limit, 1) steps.
            span    = (m_k < m_limit) ? m_k : m_limit;
            m_count = (m_mode == 0) ? span : m_limit - span;
            if (m_k >= ((m_limit > 0) ? m_limit : 1)) begin
              e_done  = 1'b1;
              m_phase = 0;
            end
          end
          2: begin
            // Triangle of period 2*limit.
            if (m_limit > 0) begin
              p       = m_k % (2 * m_limit);
              m_count = (p <= m_limit) ? p : 2 * m_limit - p;
              e_turn  = (p == 0) || (p == m_limit);
              m_dir   = (p < m_limit) ? 1 : 0;
            end
          end
          default: begin
            // Sawtooth of period limit+1.
            m_count = m_k % (m_limit + 1);
            e_turn  = (m_count == 0);
          end
        endcase
      end
    end
    e_count = m_count[W-1:0];
    exp_q.push_back({(m_phase != 2), (m_phase == 2), (m_dir != 0),
                     e_done, e_turn, e_count});
  endtask

  always @(posedge clk) model_edge();

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W+4:0] exp_v;
    logic [W+4:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {cfg_ready, busy, dir, done, turn, count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t (state %0d): actual rdy=%b busy=%b dir=%b done=%b turn=%b count=%0d, expected rdy=%b busy=%b dir=%b done=%b turn=%b count=%0d",
                 $time, state_dbg,
                 act_v[W+4], act_v[W+3], act_v[W+2], act_v[W+1], act_v[W], act_v[W-1:0],
                 exp_v[W+4], exp_v[W+3], exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge, away from both the
  // sampling edge and the monitor.
  task automatic drive(input logic cv, input logic [W-1:0] lim,
                       input logic [1:0] md, input logic st, input logic sp);
    @(negedge clk);
    #1;
    cfg_valid = cv;
    cfg_limit = lim;
    cfg_mode  = md;
    start     = st;
    stop      = sp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, W'($urandom), 2'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic do_cfg(input int lim, input logic [1:0] md);
    drive(1'b1, W'(lim), md, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    drive(1'b0, W'($urandom), 2'($urandom), 1'b1, 1'b0);
  endtask

  task automatic do_stop();
    drive(1'b0, W'($urandom), 2'($urandom), 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_limit = '0;
    cfg_mode  = 2'b00;
    start     = 1'b0;
    stop      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // reset in the middle of an up run
    do_cfg(9, MODE_ONESHOT_UP); do_start(); idle(5 * STEP_EVERY);
    do_reset(2);
    checks++;
    if (count !== '0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset @%0t: actual count=%0d busy=%b rdy=%b, expected count=0 busy=0 rdy=1",
               $time, count, busy, cfg_ready);
    end
    checks++;
    if (done !== 1'b0 || turn !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses @%0t: actual done=%b turn=%b, expected done=0 turn=0",
               $time, done, turn);
    end
    idle(2);

    // one-shot up to 3
    do_cfg(3, MODE_ONESHOT_UP); do_start(); idle(5 * STEP_EVERY);
    checks++;
    if (state_dbg !== IDLE || busy !== 1'b0 || count !== W'(3)) begin
      errors++;
      $display("FAIL one-shot end @%0t: actual state=%0d busy=%b count=%0d, expected state=0 busy=0 count=3",
               $time, state_dbg, busy, count);
    end

    // one-shot down from 4
    do_cfg(4, MODE_ONESHOT_DN); do_start(); idle(6 * STEP_EVERY);

    // bounce, limit 2
    do_cfg(2, MODE_BOUNCE); do_start(); idle(8 * STEP_EVERY); do_stop(); idle(2);

    // wrap, limit 3
    do_cfg(3, MODE_WRAP); do_start(); idle(6 * STEP_EVERY); do_stop(); idle(1);

    // stop on the terminal step of a one-shot
    do_cfg(3, MODE_ONESHOT_UP); do_start(); idle(3 * STEP_EVERY - 1); do_stop(); idle(2);

    // start in IDLE ignored
    do_start(); idle(2);
    // config offered during a run is refused
    do_cfg(5, MODE_ONESHOT_UP); do_start(); idle(1); do_cfg(1, MODE_WRAP); idle(2); do_stop(); idle(1);
    // config and start together in ARMED: config wins, no run
    do_cfg(4, MODE_ONESHOT_UP); drive(1'b1, W'(7), MODE_ONESHOT_UP, 1'b1, 1'b0); idle(3);
    // stop while armed
    do_cfg(6, MODE_BOUNCE); do_stop(); do_start(); idle(2);

    // zero-limit runs in every mode
    for (int m = 0; m < 4; m++) begin
      do_cfg(0, 2'(m)); do_start(); idle(4 * STEP_EVERY); do_stop(); idle(1);
    end

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3:     do_cfg($urandom_range(0, (1 << W) - 1), 2'($urandom));
        4, 5, 6, 7:     do_start();
        8, 9:           do_stop();
        10:             do_reset($urandom_range(1, 3));
        11, 12:         drive(1'($urandom), W'($urandom), 2'($urandom),
                              1'($urandom), 1'($urandom));
        default:        idle($urandom_range(1, 8));
      endcase
    end
    idle(3);

    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (checks > 0 && errors == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d errors in %0d checks", errors, checks);
    end
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #400000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
